// File: rtl/direction_controller.sv
// direction_controller: converts debounced button pulses into the snake heading
// and a per-step move strobe. Turn requests wait in a small circular FIFO, so two
// quick presses between game ticks take effect on successive ticks. Reversals and
// repeats are rejected against the most recently queued heading.
module direction_controller #(
  parameter int DEPTH = 2
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       BtnUp,
  input  logic       BtnRight,
  input  logic       BtnDown,
  input  logic       BtnLeft,
  input  logic       Tick,
  output logic [1:0] Direction,
  output logic       Step,
  output logic       Moving,
  output logic [2:0] Pending,
  output logic       Dropped
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;
  localparam logic [2:0] DEPTH_W   = 3'(DEPTH);
  localparam logic [1:0] LAST_IDX  = 2'(DEPTH - 1);

  // Opposite heading differs only in the upper encoding bit.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  // Advance a FIFO pointer, wrapping at DEPTH.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == LAST_IDX) begin
      return 2'b00;
    end else begin
      return p + 2'b01;
    end
  endfunction

  // Step a FIFO pointer back by one, wrapping at DEPTH.
  function automatic logic [1:0] ptr_dec(input logic [1:0] p);
    if (p == 2'b00) begin
      return LAST_IDX;
    end else begin
      return p - 2'b01;
    end
  endfunction

  // Storage is sized for the largest legal DEPTH so 2-bit pointers index it
  // directly; only the first DEPTH slots are ever used.
  logic [1:0] fifo_r [4];
  logic [1:0] head_r;
  logic [1:0] tail_r;       // next write slot; the tail entry sits just behind it
  logic [2:0] count_r;
  logic [1:0] dir_r;
  logic       step_r;
  logic       moving_r;
  logic       dropped_r;

  logic       req_valid_s;
  logic [1:0] req_dir_s;
  logic       any_btn_s;
  logic       step_s;
  logic       pop_s;
  logic [2:0] count_pp_s;
  logic [1:0] dir_pp_s;
  logic [1:0] ref_s;
  logic       legal_s;
  logic       push_s;
  logic       drop_s;
  logic [2:0] count_nx_s;

  // Fixed-priority request select: Up > Right > Down > Left.
  always_comb begin
    req_valid_s = 1'b0;
    req_dir_s   = DIR_UP;
    if (BtnUp) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_UP;
    end else if (BtnRight) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_RIGHT;
    end else if (BtnDown) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_DOWN;
    end else if (BtnLeft) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_LEFT;
    end else begin
      req_valid_s = 1'b0;
      req_dir_s   = DIR_UP;
    end
  end

  // Pop first, then judge the request against the post-pop reference and occupancy.
  always_comb begin
    any_btn_s  = BtnUp | BtnRight | BtnDown | BtnLeft;
    step_s     = Tick & moving_r;
    pop_s      = step_s && (count_r != 3'd0);
    count_pp_s = count_r;
    dir_pp_s   = dir_r;
    if (pop_s) begin
      count_pp_s = count_r - 3'd1;
      dir_pp_s   = fifo_r[head_r];
    end else begin
      count_pp_s = count_r;
      dir_pp_s   = dir_r;
    end
    ref_s = dir_pp_s;
    if (count_pp_s != 3'd0) begin
      ref_s = fifo_r[ptr_dec(tail_r)];
    end else begin
      ref_s = dir_pp_s;
    end
    legal_s    = req_valid_s && (req_dir_s != ref_s) && (req_dir_s != opposite(ref_s));
    push_s     = legal_s && (count_pp_s < DEPTH_W);
    drop_s     = legal_s && !push_s;
    count_nx_s = count_pp_s;
    if (push_s) begin
      count_nx_s = count_pp_s + 3'd1;
    end else begin
      count_nx_s = count_pp_s;
    end
  end

  // State registers: heading, strobes, start flag and FIFO bookkeeping.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_r[i] <= 2'b00;
      end
      head_r    <= 2'b00;
      tail_r    <= 2'b00;
      count_r   <= 3'd0;
      dir_r     <= DIR_RIGHT;
      step_r    <= 1'b0;
      moving_r  <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      dir_r     <= dir_pp_s;
      step_r    <= step_s;
      dropped_r <= drop_s;
      count_r   <= count_nx_s;
      if (any_btn_s) begin
        moving_r <= 1'b1;
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      if (push_s) begin
        fifo_r[tail_r] <= req_dir_s;
        tail_r         <= ptr_inc(tail_r);
      end
    end
  end

  assign Direction = dir_r;
  assign Step      = step_r;
  assign Moving    = moving_r;
  assign Pending   = count_r;
  assign Dropped   = dropped_r;

endmodule
